// File: rtl/module_operand_entry_pkg.sv
// Shared keypad-calculator definitions: key codes, entry FSM states, digit width.
package pkg_calc;
    localparam int DIGIT_W = 4;

    localparam logic [3:0] KEY_ENTER = 4'hA;
    localparam logic [3:0] KEY_CLEAR = 4'hB;
    localparam logic [3:0] KEY_BKSP  = 4'hC;

    typedef enum logic [1:0] {S_A, S_B, S_DONE} entry_state_t;
endpackage

// File: rtl/module_operand_entry_bcd_shift_reg.sv
// One BCD operand register: shift a digit in at the bottom, backspace out, count digits.
module module_bcd_shift_reg #(
    parameter int N_DIGITS = 3
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  clr,
    input  logic                                  push,
    input  logic                                  pop,
    input  logic [pkg_calc::DIGIT_W-1:0]          digit,
    output logic [N_DIGITS*pkg_calc::DIGIT_W-1:0] value,
    output logic [$clog2(N_DIGITS+1)-1:0]         count,
    output logic                                  full
);
    localparam int W     = N_DIGITS * pkg_calc::DIGIT_W;
    localparam int CNT_W = $clog2(N_DIGITS + 1);

    logic [W-1:0] shl;

    // Shift-then-overwrite keeps this legal for a single-digit operand.
    always_comb begin
        shl = value << pkg_calc::DIGIT_W;
        shl[pkg_calc::DIGIT_W-1:0] = digit;
    end

    assign full = (count == CNT_W'(N_DIGITS));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            value <= '0;
            count <= '0;
        end else if (push && !full) begin
            value <= shl;
            count <= count + CNT_W'(1);
        end else if (pop && count != '0) begin
            value <= value >> pkg_calc::DIGIT_W;
            count <= count - CNT_W'(1);
        end
    end
endmodule

// File: rtl/module_operand_entry.sv
// Keypad operand entry: builds BCD operands A then B, holds them until the ALU consumes.
module module_operand_entry
    import pkg_calc::*;
#(
    parameter int N_DIGITS = 3,
    parameter int DIGIT_W  = pkg_calc::DIGIT_W
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              key_valid,
    input  logic [3:0]                        key_code,
    input  logic                              consume,
    output logic [N_DIGITS*DIGIT_W-1:0]       a,
    output logic [N_DIGITS*DIGIT_W-1:0]       b,
    output logic [$clog2(N_DIGITS+1)-1:0]     cnt_a,
    output logic [$clog2(N_DIGITS+1)-1:0]     cnt_b,
    output logic                              sel_b,
    output logic                              operands_valid,
    output logic                              overflow
);
    localparam int W     = N_DIGITS * DIGIT_W;
    localparam int CNT_W = $clog2(N_DIGITS + 1);

    entry_state_t state, state_nxt;

    logic [1:0][W-1:0]     val;
    logic [1:0][CNT_W-1:0] cnt;
    logic [1:0]            full, clr, push, pop, active;
    logic                  is_digit, k_enter, k_clear, k_bksp, take, ovf_nxt;

    assign is_digit = key_valid && (key_code <= 4'd9);
    assign k_enter  = key_valid && (key_code == KEY_ENTER);
    assign k_clear  = key_valid && (key_code == KEY_CLEAR);
    assign k_bksp   = key_valid && (key_code == KEY_BKSP);
    // consume only means something once both operands are done; it beats any key there
    assign take     = consume && (state == S_DONE);

    assign active[0] = (state == S_A);
    assign active[1] = (state == S_B);

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            push[i] = is_digit && active[i];
            pop[i]  = k_bksp && active[i];
            clr[i]  = take || (k_clear && (active[i] || state == S_DONE));
        end
    end

    assign ovf_nxt = is_digit && ((active[0] && full[0]) || (active[1] && full[1]));

    always_comb begin
        state_nxt = state;
        if (take) begin
            state_nxt = S_A;
        end else begin
            case (state)
                S_A:     if (k_enter && cnt[0] != '0) state_nxt = S_B;
                S_B:     if (k_enter && cnt[1] != '0) state_nxt = S_DONE;
                S_DONE:  if (k_clear) state_nxt = S_A;
                default: state_nxt = S_A;
            endcase
        end
    end

    genvar g;
    generate
        for (g = 0; g < 2; g++) begin : g_opnd
            module_bcd_shift_reg #(.N_DIGITS(N_DIGITS)) u_sr (
                .clk   (clk),
                .rst   (rst),
                .clr   (clr[g]),
                .push  (push[g]),
                .pop   (pop[g]),
                .digit (key_code),
                .value (val[g]),
                .count (cnt[g]),
                .full  (full[g])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_A;
            sel_b          <= 1'b0;
            operands_valid <= 1'b0;
            overflow       <= 1'b0;
        end else begin
            state          <= state_nxt;
            sel_b          <= (state_nxt == S_B);
            operands_valid <= (state_nxt == S_DONE);
            overflow       <= ovf_nxt;
        end
    end

    assign a     = val[0];
    assign b     = val[1];
    assign cnt_a = cnt[0];
    assign cnt_b = cnt[1];
endmodule

// File: tb/tb_module_operand_entry.sv
// Scoreboard bench: each driven cycle queues its expected post-edge outputs; a monitor compares.
module tb_module_operand_entry;
    typedef struct packed {
        logic [11:0] a;
        logic [11:0] b;
        logic [1:0]  ca;
        logic [1:0]  cb;
        logic        sel;
        logic        ov;
        logic        of;
    } snap_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        key_valid = 1'b0;
    logic [3:0]  key_code = 4'h0;
    logic        consume = 1'b0;
    logic [11:0] a, b;
    logic [1:0]  cnt_a, cnt_b;
    logic        sel_b, operands_valid, overflow;

    logic        obs = 1'b0;
    snap_t       exp_q[$];
    string       name_q[$];
    int          n_chk = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    module_operand_entry #(.N_DIGITS(3), .DIGIT_W(4)) dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
        .consume(consume), .a(a), .b(b), .cnt_a(cnt_a), .cnt_b(cnt_b),
        .sel_b(sel_b), .operands_valid(operands_valid), .overflow(overflow)
    );

    function automatic snap_t mk(input logic [11:0] ea, input logic [11:0] eb,
                                 input logic [1:0] eca, input logic [1:0] ecb,
                                 input logic esel, input logic eov, input logic eof);
        snap_t s;
        s.a = ea; s.b = eb; s.ca = eca; s.cb = ecb; s.sel = esel; s.ov = eov; s.of = eof;
        return s;
    endfunction

    // Drive one cycle of inputs and queue what the outputs must be after the edge.
    task automatic step(input string nm, input logic r, input logic kv,
                        input logic [3:0] code, input logic cons, input snap_t e);
        @(negedge clk);
        rst = r; key_valid = kv; key_code = code; consume = cons; obs = 1'b1;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic key(input string nm, input logic [3:0] code, input snap_t e);
        step(nm, 1'b0, 1'b1, code, 1'b0, e);
    endtask

    // Monitor: every observed cycle pops one expectation and checks it just after the edge.
    initial begin
        forever begin
            @(posedge clk);
            if (obs) begin
                snap_t got, want;
                string nm;
                #1;
                got = mk(a, b, cnt_a, cnt_b, sel_b, operands_valid, overflow);
                if (exp_q.size() == 0) begin
                    n_chk++; n_err++;
                    $display("FAIL scoreboard_underflow: output seen with no expectation");
                end else begin
                    want = exp_q.pop_front();
                    nm   = name_q.pop_front();
                    n_chk++;
                    if (got !== want) begin
                        n_err++;
                        $display("FAIL %s: got a=%h b=%h ca=%0d cb=%0d sel=%b ov=%b of=%b, want a=%h b=%h ca=%0d cb=%0d sel=%b ov=%b of=%b",
                                 nm, got.a, got.b, got.ca, got.cb, got.sel, got.ov, got.of,
                                 want.a, want.b, want.ca, want.cb, want.sel, want.ov, want.of);
                    end
                end
            end
        end
    end

    initial begin
        step("reset", 1'b1, 1'b0, 4'h0, 1'b0, mk(12'h000, 12'h000, 0, 0, 0, 0, 0));

        // basic A then B entry
        key("a_1",      4'h1, mk(12'h001, 12'h000, 1, 0, 0, 0, 0));
        key("a_2",      4'h2, mk(12'h012, 12'h000, 2, 0, 0, 0, 0));
        key("a_3",      4'h3, mk(12'h123, 12'h000, 3, 0, 0, 0, 0));
        key("enter_a",  4'hA, mk(12'h123, 12'h000, 3, 0, 1, 0, 0));
        key("b_4",      4'h4, mk(12'h123, 12'h004, 3, 1, 1, 0, 0));
        key("b_5",      4'h5, mk(12'h123, 12'h045, 3, 2, 1, 0, 0));
        key("enter_b",  4'hA, mk(12'h123, 12'h045, 3, 2, 0, 1, 0));
        step("done_idle", 1'b0, 1'b0, 4'h7, 1'b0, mk(12'h123, 12'h045, 3, 2, 0, 1, 0));
        key("done_dig", 4'h7, mk(12'h123, 12'h045, 3, 2, 0, 1, 0));
        key("done_bksp",4'hC, mk(12'h123, 12'h045, 3, 2, 0, 1, 0));
        key("done_ent", 4'hA, mk(12'h123, 12'h045, 3, 2, 0, 1, 0));
        step("consume_clr", 1'b0, 1'b1, 4'hB, 1'b1, mk(12'h000, 12'h000, 0, 0, 0, 0, 0));

        // overflow on a full operand
        key("ov_7",     4'h7, mk(12'h007, 12'h000, 1, 0, 0, 0, 0));
        key("ov_8",     4'h8, mk(12'h078, 12'h000, 2, 0, 0, 0, 0));
        key("ov_9",     4'h9, mk(12'h789, 12'h000, 3, 0, 0, 0, 0));
        key("ov_6",     4'h6, mk(12'h789, 12'h000, 3, 0, 0, 0, 1));
        step("ov_drop", 1'b0, 1'b0, 4'h6, 1'b0, mk(12'h789, 12'h000, 3, 0, 0, 0, 0));
        key("ov_ign_f", 4'hF, mk(12'h789, 12'h000, 3, 0, 0, 0, 0));
        key("clr_a",    4'hB, mk(12'h000, 12'h000, 0, 0, 0, 0, 0));

        // backspace down to empty, then an ignored ENTER
        key("bk_5",     4'h5, mk(12'h005, 12'h000, 1, 0, 0, 0, 0));
        key("bk_6",     4'h6, mk(12'h056, 12'h000, 2, 0, 0, 0, 0));
        key("bk_1",     4'hC, mk(12'h005, 12'h000, 1, 0, 0, 0, 0));
        key("bk_2",     4'hC, mk(12'h000, 12'h000, 0, 0, 0, 0, 0));
        key("bk_3",     4'hC, mk(12'h000, 12'h000, 0, 0, 0, 0, 0));
        key("ent_empty",4'hA, mk(12'h000, 12'h000, 0, 0, 0, 0, 0));

        // CLEAR in B only touches B; consume outside S_DONE ignored
        key("cb_3",     4'h3, mk(12'h003, 12'h000, 1, 0, 0, 0, 0));
        key("cb_ent",   4'hA, mk(12'h003, 12'h000, 1, 0, 1, 0, 0));
        key("cb_9",     4'h9, mk(12'h003, 12'h009, 1, 1, 1, 0, 0));
        key("cb_clr",   4'hB, mk(12'h003, 12'h000, 1, 0, 1, 0, 0));
        key("cb_ent0",  4'hA, mk(12'h003, 12'h000, 1, 0, 1, 0, 0));
        step("cons_in_b", 1'b0, 1'b0, 4'h0, 1'b1, mk(12'h003, 12'h000, 1, 0, 1, 0, 0));
        key("cb_ign_e", 4'hE, mk(12'h003, 12'h000, 1, 0, 1, 0, 0));
        key("cb_0",     4'h0, mk(12'h003, 12'h000, 1, 1, 1, 0, 0));
        key("cb_ent1",  4'hA, mk(12'h003, 12'h000, 1, 1, 0, 1, 0));
        step("consume", 1'b0, 1'b0, 4'h0, 1'b1, mk(12'h000, 12'h000, 0, 0, 0, 0, 0));

        // mid-entry reset, with a key present in the reset cycle
        key("rs_1",     4'h1, mk(12'h001, 12'h000, 1, 0, 0, 0, 0));
        key("rs_2",     4'h2, mk(12'h012, 12'h000, 2, 0, 0, 0, 0));
        key("rs_ent",   4'hA, mk(12'h012, 12'h000, 2, 0, 1, 0, 0));
        key("rs_ign_e", 4'hE, mk(12'h012, 12'h000, 2, 0, 1, 0, 0));
        step("rst_mid", 1'b1, 1'b1, 4'h5, 1'b0, mk(12'h000, 12'h000, 0, 0, 0, 0, 0));

        // full again then CLEAR from S_DONE
        key("dc_4",     4'h4, mk(12'h004, 12'h000, 1, 0, 0, 0, 0));
        key("dc_ent",   4'hA, mk(12'h004, 12'h000, 1, 0, 1, 0, 0));
        key("dc_8",     4'h8, mk(12'h004, 12'h008, 1, 1, 1, 0, 0));
        key("dc_ent2",  4'hA, mk(12'h004, 12'h008, 1, 1, 0, 1, 0));
        key("dc_clr",   4'hB, mk(12'h000, 12'h000, 0, 0, 0, 0, 0));

        @(negedge clk);
        rst = 1'b0; key_valid = 1'b0; consume = 1'b0; obs = 1'b0;
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_chk++; n_err++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/module_operand_entry.md
Name: module_operand_entry

Overview:
Parametrised multi-digit operand capture for the keypad calculator datapath. It takes one decoded keypad code per valid strobe and builds two BCD operands, A then B, by shifting digits in. It supports enter, clear and backspace, and holds both operands stable until the downstream ALU consumes them. It replaces single-nibble A/B load registers and sits between the keypad decoder and the arithmetic unit.

Parameters:
N_DIGITS, 3, maximum BCD digits per operand (1..8)
DIGIT_W, 4, bits per digit (fixed 4 for BCD; parameter for package consistency)

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
key_valid  input  1  one-cycle strobe, key_code valid
key_code  input  4  0x0-0x9 digit, 0xA ENTER, 0xB CLEAR, 0xC BACKSPACE, 0xD-0xF ignored
consume  input  1  one-cycle pulse from ALU: operands taken
a  output  N_DIGITS*DIGIT_W  operand A, BCD, least-significant digit in [3:0]
b  output  N_DIGITS*DIGIT_W  operand B, BCD, same packing
cnt_a  output  $clog2(N_DIGITS+1)  digits entered in A
cnt_b  output  $clog2(N_DIGITS+1)  digits entered in B
sel_b  output  1  0 = editing A, 1 = editing B
operands_valid  output  1  level, high in S_DONE
overflow  output  1  one-cycle pulse: digit rejected because the operand is full

Behaviour:
- Reset: a=b=0, cnt_a=cnt_b=0, state S_A, sel_b=0, operands_valid=0, overflow=0. Reset overrides all inputs, including mid-entry.
- All outputs are registered. A key's effect is visible on the first clk edge after the cycle in which key_valid=1, so latency is 1 cycle. Inputs are ignored when key_valid=0.
- States S_A, S_B, S_DONE. sel_b=1 only in S_B. operands_valid=1 only in S_DONE.
- Digit key in S_A/S_B:
  - if cnt < N_DIGITS: operand <= {operand[(N-1)*4-1:0], key_code}; cnt++.
  - else: operand unchanged; overflow pulses for 1 cycle.
  - Leading zeros are accepted and counted.
- BACKSPACE in S_A/S_B:
  - if cnt > 0: operand <= operand >> 4 (zero fill at top); cnt--.
  - else: ignored.
- CLEAR:
  - S_A: a=0, cnt_a=0.
  - S_B: b=0, cnt_b=0; stays in S_B.
  - S_DONE: clears everything and goes to S_A.
- ENTER:
  - S_A with cnt_a > 0 -> S_B.
  - S_B with cnt_b > 0 -> S_DONE.
  - ENTER with cnt=0 is ignored.
- S_DONE: digit, BACKSPACE and ENTER keys are ignored; a, b and the counts hold.
- consume:
  - In S_DONE: clears a, b and both counts, goes to S_A.
  - Outside S_DONE: ignored.
  - consume and key_valid in the same S_DONE cycle: consume wins and the key is dropped, even if it is CLEAR.
- Codes 0xD-0xF: no state or data change, no overflow.
- The digit value is never range-checked beyond the 0-9 decode; codes are trusted from the decoder.

Decomposition:
- Package pkg_calc:
  - key code constants KEY_ENTER=4'hA, KEY_CLEAR=4'hB, KEY_BKSP=4'hC.
  - typedef enum logic [1:0] {S_A, S_B, S_DONE} entry_state_t.
  - DIGIT_W constant.
- Sub-module module_bcd_shift_reg (params N_DIGITS):
  - inputs: clk, rst, clr, push, pop, digit.
  - outputs: value, count, full.
  - instantiated twice, for A and B.
  - owns shift, backspace and count logic, and full detection.
- The top owns the FSM, key decode, overflow pulse and the consume handling.

Test Plan:
- Reset, then keys 1,2,3,ENTER,4,5,ENTER -> a=12'h123, cnt_a=3, b=12'h045, cnt_b=2, operands_valid=1, sel_b=0.
- In S_A enter 7,8,9, then 6 -> a stays 12'h789; overflow high exactly 1 cycle; cnt_a=3.
- Keys 5,6,BKSP,BKSP,BKSP -> a=0x056, a=0x005, a=0, then the third BKSP is ignored; ENTER with cnt_a=0 stays in S_A.
- Reach S_DONE, then assert consume and key_valid(key 0xB) in the same cycle -> next cycle S_A, a=b=0, counts 0; key dropped.
- Keys 3,ENTER,9,CLEAR,ENTER -> still S_B with b=0 (CLEAR clears only B; ENTER with cnt_b=0 ignored); a=0x003 retained.
- Mid-entry rst (a=0x012, S_B) -> all outputs return to reset values on the next edge; key 0xE at any time produces no change.
